button_debounce_array: RTL and testbench



---
 rtl/button_debounce_array_if.sv | 19 +
 rtl/button_debounce_array.sv | 87 ++++++++
 tb/tb_button_debounce_array.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_array_if.sv
// button_debounce_array_if: sample strobe, raw buttons and conditioned outputs of button_debounce_array.
interface button_debounce_array_if #(
    parameter int N_CH = 6
);
    logic            i_ena;
    logic [N_CH-1:0] i_btn;
    logic [N_CH-1:0] o_level;
    logic [N_CH-1:0] o_press_pulse;
    logic [N_CH-1:0] o_release_pulse;
    logic [N_CH-1:0] o_repeat_pulse;
    modport master (
        output i_ena, i_btn,
        input  o_level, o_press_pulse, o_release_pulse, o_repeat_pulse
    );
    modport slave (
        input  i_ena, i_btn,
        output o_level, o_press_pulse, o_release_pulse, o_repeat_pulse
    );
endinterface

// File: rtl/button_debounce_array.sv
// button_debounce_array: per-channel sync, strobe-based debounce and press/release pulses.
// Hold-to-repeat pulses are built only when DEBOUNCE_AUTOREPEAT_EN is defined.
module button_debounce_array #(
    parameter int              N_CH        = 6,
    parameter int              STABLE_CNT  = 3,
    parameter int              REPEAT_DLY  = 60,
    parameter int              REPEAT_RATE = 12,
    parameter logic [N_CH-1:0] ACT_LOW     = '0
) (
    input logic                    i_clk,
    input logic                    i_reset,
    button_debounce_array_if.slave bus
);
    localparam int CW = $clog2(STABLE_CNT + 1);
    logic [N_CH-1:0] sync1, sync2, s, level, done, press_p, rel_p;
    logic [CW-1:0]   cnt [N_CH];
    assign s = sync2 ^ ACT_LOW;
    // done: this strobe completes STABLE_CNT consecutive samples disagreeing with the level
    always_comb begin
        for (int i = 0; i < N_CH; i++)
            done[i] = bus.i_ena && s[i] != level[i] && cnt[i] == CW'(STABLE_CNT - 1);
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            press_p <= '0;
            rel_p   <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            sync1   <= bus.i_btn;
            sync2   <= sync1;
            level   <= level ^ done;
            press_p <= done & ~level;
            rel_p   <= done & level;
            for (int i = 0; i < N_CH; i++)
                if (bus.i_ena) cnt[i] <= (s[i] == level[i] || done[i]) ? '0 : cnt[i] + CW'(1);
        end
    end
    assign bus.o_level         = level;
    assign bus.o_press_pulse   = press_p;
    assign bus.o_release_pulse = rel_p;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RMAX = REPEAT_DLY > REPEAT_RATE ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    state_t          st [N_CH], st_nx [N_CH];
    logic [RW-1:0]   rcnt [N_CH], rcnt_nx [N_CH];
    logic [N_CH-1:0] rep, rep_nx;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rep <= '0;
            for (int i = 0; i < N_CH; i++) begin
                st[i]   <= IDLE;
                rcnt[i] <= '0;
            end
        end else begin
            rep <= rep_nx;
            for (int i = 0; i < N_CH; i++) begin
                st[i]   <= st_nx[i];
                rcnt[i] <= rcnt_nx[i];
            end
        end
    end
    // a debounced edge overrides counting, so release never coincides with a repeat
    always_comb begin
        rep_nx = '0;
        for (int i = 0; i < N_CH; i++) begin
            st_nx[i]   = st[i];
            rcnt_nx[i] = rcnt[i];
            if (done[i]) begin
                st_nx[i]   = level[i] ? IDLE : HOLD;
                rcnt_nx[i] = '0;
            end else if (bus.i_ena && st[i] != IDLE) begin
                rep_nx[i]  = rcnt[i] == (st[i] == HOLD ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_RATE - 1));
                rcnt_nx[i] = rep_nx[i] ? '0 : rcnt[i] + RW'(1);
                st_nx[i]   = rep_nx[i] ? REPEAT : st[i];
            end
        end
    end
    assign bus.o_repeat_pulse = rep;
`else
    localparam int unused_repeat_cfg = REPEAT_DLY + REPEAT_RATE;
    assign bus.o_repeat_pulse = '0;
`endif
endmodule

// File: tb/tb_button_debounce_array.sv
// tb_button_debounce_array: directed scenarios checked against a strobe-counting model every cycle.
module tb_button_debounce_array;
    localparam int         N  = 4;
    localparam int         SC = 3;
    localparam int         RD = 4;
    localparam int         RR = 2;
    localparam logic [3:0] AL = 4'b1000;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    button_debounce_array_if #(.N_CH(N)) bus ();
    button_debounce_array #(
        .N_CH(N), .STABLE_CNT(SC), .REPEAT_DLY(RD), .REPEAT_RATE(RR), .ACT_LOW(AL)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus)
    );
    int total = 0;
    int bad = 0;
    int shown = 0;
    int press_n [N];
    int rel_n [N];
    int rep_n [N];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (shown < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            shown++;
        end
    endtask
    // model: pressed state follows s once STABLE_CNT consecutive strobes disagree;
    // repeats fire when the number of strobes held since the press hits RD, RD+RR, RD+2RR, ...
    logic [N-1:0] h1, h2, s_m, m_lev, m_press, m_rel, m_rep;
    int run [N];
    int held [N];
    initial begin
        h1 = '0; h2 = '0; m_lev = '0; m_press = '0; m_rel = '0; m_rep = '0;
        for (int c = 0; c < N; c++) begin
            run[c] = 0; held[c] = 0; press_n[c] = 0; rel_n[c] = 0; rep_n[c] = 0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                h1 = '0; h2 = '0; m_lev = '0; m_press = '0; m_rel = '0; m_rep = '0;
                for (int c = 0; c < N; c++) begin
                    run[c] = 0; held[c] = 0;
                end
            end else begin
                s_m = h2 ^ AL;
                h2 = h1;
                h1 = bus.i_btn;
                m_press = '0; m_rel = '0; m_rep = '0;
                if (bus.i_ena) begin
                    for (int c = 0; c < N; c++) begin
                        run[c] = (s_m[c] == m_lev[c]) ? 0 : run[c] + 1;
                        if (run[c] == SC) begin
                            run[c] = 0;
                            m_lev[c] = ~m_lev[c];
                            if (m_lev[c]) begin
                                m_press[c] = 1'b1;
                                held[c] = 0;
                            end else m_rel[c] = 1'b1;
                        end else if (m_lev[c]) begin
                            held[c]++;
                            m_rep[c] = REP_ON && (held[c] == RD || (held[c] > RD && (held[c] - RD) % RR == 0));
                        end
                    end
                end
            end
            @(negedge clk);
            check("level", bus.o_level, m_lev);
            check("press", bus.o_press_pulse, m_press);
            check("release", bus.o_release_pulse, m_rel);
            check("repeat", bus.o_repeat_pulse, m_rep);
            for (int c = 0; c < N; c++) begin
                if (bus.o_press_pulse[c]) press_n[c]++;
                if (bus.o_release_pulse[c]) rel_n[c]++;
                if (bus.o_repeat_pulse[c]) rep_n[c]++;
            end
        end
    end
    // each call: 9 idle clocks then one strobe; returns just after the strobe edge
    task automatic strobe(input int n);
        repeat (n) begin
            repeat (9) @(negedge clk);
            bus.i_ena = 1'b1;
            @(negedge clk);
            bus.i_ena = 1'b0;
        end
    endtask
    task automatic all_zero(input string name);
        check({name, "_level"}, bus.o_level, 4'b0000);
        check({name, "_press"}, bus.o_press_pulse, 4'b0000);
        check({name, "_rel"}, bus.o_release_pulse, 4'b0000);
        check({name, "_rep"}, bus.o_repeat_pulse, 4'b0000);
    endtask
    initial begin
        int p0, q0, r0;
        logic [5:0] pat;
        bus.i_ena = 1'b0;
        bus.i_btn = 4'b1000;
        repeat (3) @(negedge clk);
        all_zero("reset");
        rst = 1'b0;
        // clean press on ch0 together with active-low ch3
        bus.i_btn = 4'b0001;
        strobe(2);
        check("clean_early", bus.o_level, 4'b0000);
        strobe(1);
        check("clean_level", bus.o_level, 4'b1001);
        check("clean_press", bus.o_press_pulse, 4'b1001);
        @(negedge clk);
        check("clean_press_width", bus.o_press_pulse, 4'b0000);
        check("clean_hold", bus.o_level, 4'b1001);
        bus.i_btn = 4'b1000;
        strobe(3);
        check("clean_release", bus.o_release_pulse, 4'b1001);
        check("clean_released", bus.o_level, 4'b0000);
        // bounce on ch1
        pat = 6'b111011;
        p0 = press_n[1];
        for (int i = 0; i < 6; i++) begin
            bus.i_btn[1] = pat[i];
            strobe(1);
            if (i == 4) check("bounce_not_yet", bus.o_level[1], 1'b0);
        end
        check("bounce_level", bus.o_level[1], 1'b1);
        check("bounce_press", bus.o_press_pulse, 4'b0010);
        bus.i_btn[1] = 1'b0;
        strobe(3);
        check("bounce_press_count", press_n[1] - p0, 1);
        // auto-repeat on ch2
        p0 = press_n[2]; q0 = rel_n[2]; r0 = rep_n[2];
        bus.i_btn[2] = 1'b1;
        strobe(3);
        check("rep_press", bus.o_press_pulse, 4'b0100);
        strobe(3);
        check("rep_before_dly", rep_n[2] - r0, 0);
        strobe(1);
        check("rep_first", bus.o_repeat_pulse, REP_ON ? 4'b0100 : 4'b0000);
        strobe(10);
        bus.i_btn[2] = 1'b0;
        strobe(3);
        check("rep_release", bus.o_release_pulse, 4'b0100);
        check("rep_release_norep", bus.o_repeat_pulse, 4'b0000);
        strobe(2);
        check("rep_total", rep_n[2] - r0, REP_ON ? 7 : 0);
        check("rep_press_count", press_n[2] - p0, 1);
        check("rep_rel_count", rel_n[2] - q0, 1);
        // reset while ch2 is repeating
        bus.i_btn[2] = 1'b1;
        strobe(9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        all_zero("midreset");
        rst = 1'b0;
        strobe(2);
        check("post_reset_wait", bus.o_level, 4'b0000);
        strobe(1);
        check("post_reset_press", bus.o_press_pulse, 4'b0100);
        r0 = rep_n[2];
        strobe(3);
        check("post_reset_no_early_rep", rep_n[2] - r0, 0);
        strobe(1);
        check("post_reset_rep", bus.o_repeat_pulse, REP_ON ? 4'b0100 : 4'b0000);
        bus.i_btn[2] = 1'b0;
        strobe(4);
        check("final_idle", bus.o_level, 4'b0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
